// File: rtl/div_pkg.sv
// Shared definitions for the divider datapath: FSM state encoding, default
// operand width and a constant-foldable ceil(log2) helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 9;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_slice_adder_if.sv
// Operand/result handshake bundle for seq_slice_adder.
interface seq_slice_adder_if import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, sub, cin, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, sub, cin, a, b, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/add_slice.sv
// Combinational SLICE-bit ripple adder; exposes the full carry chain so the
// caller can pick carries at an arbitrary bit inside the slice.
module add_slice #(
  parameter int SLICE = 3
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb_in,
  output logic [SLICE:0]   cvec
);

  logic [SLICE:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < SLICE; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cvec     = c;
  assign cout     = c[SLICE];
  assign c_msb_in = c[SLICE-1];

endmodule

// File: rtl/seq_slice_adder.sv
// Multi-cycle adder/subtractor: one SLICE-bit segment per cycle with the
// carry registered between segments, behind a valid/ready handshake.
module seq_slice_adder import div_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = 3
) (
  input logic              clk,
  input logic              rst_n,
  seq_slice_adder_if.slave bus
);

  localparam int NSLICE    = (WIDTH + SLICE - 1) / SLICE;
  localparam int LAST_BITS = WIDTH - (NSLICE - 1) * SLICE;
  localparam int KW        = (clog2(NSLICE) > 0) ? clog2(NSLICE) : 1;
  localparam int CW        = clog2(SLICE + 1);
  localparam logic [WIDTH-1:0] SMASK = WIDTH'({SLICE{1'b1}});

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      base;
  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic             sl_co, sl_cmsb;
  logic [SLICE:0]   sl_cvec;
  logic             last;
  logic [CW-1:0]    top_idx;
  logic             msb_co, msb_ci;

  assign base = 32'(k_q) * 32'(SLICE);
  assign sl_a = SLICE'(a_q >> base);
  assign sl_b = SLICE'(b_q >> base);
  assign last = (k_q == KW'(NSLICE - 1));

  add_slice #(.SLICE(SLICE)) u_slice (
    .a        (sl_a),
    .b        (sl_b),
    .cin      (carry_q),
    .s        (sl_s),
    .cout     (sl_co),
    .c_msb_in (sl_cmsb),
    .cvec     (sl_cvec)
  );

  // Flags come from bit WIDTH-1, which on a partial last slice sits below the
  // slice boundary; zero-padded operand bits above it never reach sum_q.
  assign top_idx = last ? CW'(LAST_BITS) : CW'(SLICE);
  assign msb_co  = sl_cvec[top_idx];
  assign msb_ci  = (top_idx == CW'(SLICE)) ? sl_cmsb : sl_cvec[top_idx - 1'b1];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.sub;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~(SMASK << base)) | (WIDTH'(sl_s) << base);
        carry_d = sl_co;
        if (last) begin
          cout_d  = msb_co;
          ovf_d   = msb_ci ^ msb_co;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_slice_adder.sv
// Directed and random checks of seq_slice_adder at 9/3 and 10/4 using a
// scoreboard queue filled at accept time from an arithmetic reference model.
module tb_seq_slice_adder;

  typedef struct packed {
    logic [9:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_slice_adder_if #(.WIDTH(9))  bus9 ();
  seq_slice_adder_if #(.WIDTH(10)) bus10 ();

  seq_slice_adder #(.WIDTH(9), .SLICE(3)) dut9 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus9)
  );

  seq_slice_adder #(.WIDTH(10), .SLICE(4)) dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus10)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition, overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [9:0] a, input logic [9:0] b,
                                 input logic s, input logic c);
    logic [10:0] r;
    logic [9:0]  mask, am, bb;
    exp_t        e;
    mask = '0;
    for (int i = 0; i < w; i++) mask[i] = 1'b1;
    am     = a & mask;
    bb     = (s ? ~b : b) & mask;
    r      = 11'(am) + 11'(bb) + 11'(c ^ s);
    e.sum  = r[9:0] & mask;
    e.cout = r[w];
    e.ovf  = (am[w-1] == bb[w-1]) && (r[w-1] != am[w-1]);
    return e;
  endfunction

  function automatic logic ov(input int w);
    return (w == 9) ? bus9.out_valid : bus10.out_valid;
  endfunction
  function automatic logic ir(input int w);
    return (w == 9) ? bus9.in_ready : bus10.in_ready;
  endfunction
  function automatic logic [9:0] rsum(input int w);
    return (w == 9) ? {1'b0, bus9.sum} : bus10.sum;
  endfunction
  function automatic logic rco(input int w);
    return (w == 9) ? bus9.cout : bus10.cout;
  endfunction
  function automatic logic rov(input int w);
    return (w == 9) ? bus9.ovf : bus10.ovf;
  endfunction

  task automatic set_in(input int w, input logic v, input logic [9:0] a, input logic [9:0] b,
                        input logic s, input logic c);
    if (w == 9) begin
      bus9.in_valid = v; bus9.a = a[8:0]; bus9.b = b[8:0]; bus9.sub = s; bus9.cin = c;
    end else begin
      bus10.in_valid = v; bus10.a = a; bus10.b = b; bus10.sub = s; bus10.cin = c;
    end
  endtask

  task automatic set_or(input int w, input logic v);
    if (w == 9) bus9.out_ready = v;
    else        bus10.out_ready = v;
  endtask

  task automatic accept(input int w, input logic [9:0] a, input logic [9:0] b,
                        input logic s, input logic c);
    check($sformatf("w%0d_in_ready_idle", w), 32'(ir(w)), 32'd1);
    set_in(w, 1'b1, a, b, s, c);
    sb.push_back(model(w, a, b, s, c));
    @(posedge clk); #1;
    set_in(w, 1'b0, 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic finish(input int w, input int hold, input int exp_lat);
    int   lat;
    exp_t e;
    lat = 0;
    check($sformatf("w%0d_in_ready_run", w), 32'(ir(w)), 32'd0);
    while (!ov(w) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("w%0d_latency", w), 32'(lat), 32'(exp_lat));
    e = sb.pop_front();
    check($sformatf("w%0d_sum", w),  32'(rsum(w)), 32'(e.sum));
    check($sformatf("w%0d_cout", w), 32'(rco(w)),  32'(e.cout));
    check($sformatf("w%0d_ovf", w),  32'(rov(w)),  32'(e.ovf));
    for (int i = 0; i < hold; i++) begin
      set_in(w, 1'b1, 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk); #1;
      check($sformatf("w%0d_hold_valid", w), 32'(ov(w)), 32'd1);
      check($sformatf("w%0d_hold_ready", w), 32'(ir(w)), 32'd0);
      check($sformatf("w%0d_hold_sum", w), {21'd0, rsum(w), rco(w), rov(w)},
            {21'd0, e.sum, e.cout, e.ovf});
    end
    set_in(w, 1'b0, '0, '0, 1'b0, 1'b0);
    set_or(w, 1'b1);
    @(posedge clk); #1;
    set_or(w, 1'b0);
    check($sformatf("w%0d_valid_drop", w), 32'(ov(w)), 32'd0);
    check($sformatf("w%0d_back_idle", w),  32'(ir(w)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    set_in(9, 1'b0, '0, '0, 1'b0, 1'b0);
    set_in(10, 1'b0, '0, '0, 1'b0, 1'b0);
    set_or(9, 1'b0);
    set_or(10, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(ir(9)),   32'd1);
    check("rst_out_valid", 32'(ov(9)),   32'd0);
    check("rst_sum",       32'(rsum(9)), 32'd0);
    check("rst_cout",      32'(rco(9)),  32'd0);
    check("rst_ovf",       32'(rov(9)),  32'd0);
    check("rst10_state",   {30'd0, ir(10), ov(10)}, 32'd2);
    rst_n = 1'b1;
    @(posedge clk); #1;

    accept(9, 10'h07F, 10'h001, 1'b0, 1'b0); finish(9, 0, 3);
    accept(9, 10'h0FF, 10'h001, 1'b0, 1'b0); finish(9, 0, 3);
    accept(9, 10'h1FF, 10'h001, 1'b0, 1'b0); finish(9, 0, 3);
    accept(9, 10'h005, 10'h007, 1'b1, 1'b0); finish(9, 0, 3);
    accept(9, 10'h0AB, 10'h155, 1'b1, 1'b1); finish(9, 5, 3);
    accept(9, 10'h100, 10'h100, 1'b0, 1'b1); finish(9, 1, 3);

    // Abort one cycle into RUN; the previous nonzero sum must clear.
    accept(9, 10'h123, 10'h045, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(ov(9)),   32'd0);
    check("abort_sum",       32'(rsum(9)), 32'd0);
    check("abort_cout",      32'(rco(9)),  32'd0);
    check("abort_in_ready",  32'(ir(9)),   32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    void'(sb.pop_back());
    @(posedge clk); #1;
    check("abort_ready_after", 32'(ir(9)), 32'd1);
    accept(9, 10'h0F0, 10'h00F, 1'b0, 1'b1); finish(9, 0, 3);

    for (int i = 0; i < 8; i++) begin
      accept(9, 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom));
      finish(9, int'($urandom_range(0, 2)), 3);
    end

    accept(10, 10'h3FF, 10'h001, 1'b0, 1'b0); finish(10, 0, 3);
    accept(10, 10'h1FF, 10'h001, 1'b0, 1'b0); finish(10, 0, 3);
    accept(10, 10'h200, 10'h001, 1'b1, 1'b0); finish(10, 2, 3);
    accept(10, 10'h000, 10'h000, 1'b1, 1'b1); finish(10, 0, 3);
    for (int i = 0; i < 6; i++) begin
      accept(10, 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom));
      finish(10, int'($urandom_range(0, 1)), 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
